// File: rtl/cdb_result_buffer.sv
// First-word-fall-through result FIFO between a functional unit's writeback and the
// CDB broadcast register. It absorbs results while the CDB grant is withheld.
module cdb_result_buffer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic [TAG_W-1:0]           in_tag_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [TAG_W-1:0]           out_tag_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH+1);
  localparam int unsigned EntryW = DATA_W + TAG_W;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic full, empty, push, pop, wr_en;

  always_comb begin
    full  = (cnt_q == CntW'(DEPTH));
    empty = (cnt_q == '0);
    push  = in_valid_i & ~full;
    pop   = out_ready_i & ~empty;
    // A flush squashes any push in the same cycle, so the array is left untouched.
    wr_en = push & ~flush_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      cnt_d    = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= {in_data_i, in_tag_i};
    end
  end

  // No empty bypass: outputs come from storage only, and in_ready ignores out_ready.
  always_comb begin
    in_ready_o              = ~full;
    out_valid_o             = ~empty;
    {out_data_o, out_tag_o} = mem_q[rd_ptr_q];
    count_o                 = cnt_q;
  end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Scoreboard bench for cdb_result_buffer: the driver maintains an expected-content queue,
// and a negedge monitor compares occupancy, handshakes and the head entry against it.
module tb_cdb_result_buffer;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CntW   = $clog2(DEPTH+1);

  logic              clk;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [TAG_W-1:0]  in_tag, out_tag;
  logic [CntW-1:0]   count;

  logic [DATA_W+TAG_W-1:0] exp_q[$];
  bit zero_flag = 1'b0;
  bit mon_en    = 1'b0;
  int n_vec     = 0;
  int n_err     = 0;

  cdb_result_buffer #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_tag_i    (in_tag),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_tag_o   (out_tag),
    .out_ready_i (out_ready),
    .count_o     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 70'(count), 70'(exp_q.size()));
      check("out_valid", 70'(out_valid), 70'(exp_q.size() != 0));
      check("in_ready", 70'(in_ready), 70'(exp_q.size() < DEPTH));
      if (exp_q.size() != 0) begin
        check("head_entry", {out_data, out_tag}, exp_q[0]);
      end else if (zero_flag) begin
        check("reset_entry", {out_data, out_tag}, 70'd0);
      end
    end
  end

  // Apply one cycle of inputs, then advance the reference queue at the clock edge.
  task automatic cyc(input bit r, input bit f, input bit iv, input logic [DATA_W-1:0] d,
                     input logic [TAG_W-1:0] t, input bit ordy);
    bit acc, pp;
    reset     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    in_tag    = t;
    out_ready = ordy;
    @(posedge clk);
    acc = iv && (exp_q.size() < DEPTH);
    pp  = ordy && (exp_q.size() != 0);
    if (r) begin
      exp_q.delete();
      zero_flag = 1'b1;
    end else if (f) begin
      exp_q.delete();
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({d, t});
        zero_flag = 1'b0;
      end
    end
    mon_en = 1'b1;
    #1;
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(1'b0);

    // Three pushes while grant is withheld, then drain.
    cyc(1'b0, 1'b0, 1'b1, 64'hA, 6'd1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 64'hB, 6'd2, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 64'hC, 6'd3, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    idle(1'b0);

    // Fill, then a held push against a full buffer while popping.
    for (int i = 4; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 64'(i), 6'(i), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 64'hE, 6'd14, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 64'hE, 6'd14, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Streaming at occupancy 1 across several pointer wraps.
    cyc(1'b0, 1'b0, 1'b1, 64'h100, 6'd10, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 64'(i), 6'(i), 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Flush with three buffered, colliding with push and pop.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 64'(32 + i), 6'(20 + i), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 64'hDEAD, 6'd33, 1'b1);
    idle(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 64'h55, 6'd9, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Reset colliding with flush and push, two entries buffered.
    cyc(1'b0, 1'b0, 1'b1, 64'h77, 6'd7, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 64'h78, 6'd8, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 64'h79, 6'd9, 1'b1);
    idle(1'b0);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) < 7), {$urandom, $urandom}, 6'($urandom),
          ($urandom_range(0, 9) < 5));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
